// File: rtl/motor_cmd_ctrl_if.sv
// Command/output bundle between the motion-command sources, motor_cmd_ctrl and the PWM generator.
// master drives the requests and estop; slave is the controller that produces the wheel commands.
interface motor_cmd_ctrl_if #(
    parameter int SPEED_W = 14
);
    logic               a_valid;
    logic               a_dir_l;
    logic               a_dir_r;
    logic [SPEED_W-1:0] a_speed_l;
    logic [SPEED_W-1:0] a_speed_r;
    logic               b_dir_l;
    logic               b_dir_r;
    logic [SPEED_W-1:0] b_speed_l;
    logic [SPEED_W-1:0] b_speed_r;
    logic               estop;
    logic               dir_l;
    logic               dir_r;
    logic [SPEED_W-1:0] speed_l;
    logic [SPEED_W-1:0] speed_r;
    logic               grant_a;
    logic               settled;

    modport master (
        output a_valid, a_dir_l, a_dir_r, a_speed_l, a_speed_r,
        output b_dir_l, b_dir_r, b_speed_l, b_speed_r, estop,
        input  dir_l, dir_r, speed_l, speed_r, grant_a, settled
    );

    modport slave (
        input  a_valid, a_dir_l, a_dir_r, a_speed_l, a_speed_r,
        input  b_dir_l, b_dir_r, b_speed_l, b_speed_r, estop,
        output dir_l, dir_r, speed_l, speed_r, grant_a, settled
    );
endinterface

// File: rtl/motor_cmd_ctrl.sv
// Arbitrates two motion requesters and slew-limits each wheel, routing every direction
// reversal through zero speed plus a dead time before the PWM generator sees it.
//
// state | meaning
// RUN   | direction matches target; speed slews toward target on each tick
// DECEL | reversal pending; speed falls by STEP per tick until zero
// DEAD  | speed held at zero for DEAD_TICKS ticks, then direction flips
module motor_cmd_ctrl #(
    parameter int SPEED_W    = 14,
    parameter int MAX_SPEED  = 11000,
    parameter int STEP       = 64,
    parameter int TICK_DIV   = 1000,
    parameter int DEAD_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    motor_cmd_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DC_W = $clog2(DEAD_TICKS + 1);
    localparam logic [SPEED_W:0]   STEP_X = (SPEED_W + 1)'(STEP);
    localparam logic [SPEED_W-1:0] STEP_S = SPEED_W'(STEP);
    localparam logic [SPEED_W-1:0] MAX_S  = SPEED_W'(MAX_SPEED);

    logic [PS_W-1:0]    ps_cnt;
    logic               tick;

    logic [1:0]         sel_dir;
    logic [SPEED_W-1:0] sel_spd [2];
    logic [1:0]         tgt_dir;
    logic [SPEED_W-1:0] tgt_spd [2];
    logic               grant_q;

    state_t             state_q [2];
    state_t             state_d [2];
    logic [SPEED_W-1:0] spd_q   [2];
    logic [SPEED_W-1:0] spd_d   [2];
    logic [1:0]         dir_q;
    logic [1:0]         dir_d;
    logic [DC_W-1:0]    dcnt_q  [2];
    logic [DC_W-1:0]    dcnt_d  [2];
    logic [SPEED_W:0]   diff    [2];
    logic               settled_d;
    logic               settled_q;

    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            ps_cnt <= '0;
        else
            ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end

    // Owner switches on the very cycle a_valid changes; targets clamp before registering.
    always_comb begin
        sel_dir    = bus.a_valid ? {bus.a_dir_r, bus.a_dir_l} : {bus.b_dir_r, bus.b_dir_l};
        sel_spd[0] = bus.a_valid ? bus.a_speed_l : bus.b_speed_l;
        sel_spd[1] = bus.a_valid ? bus.a_speed_r : bus.b_speed_r;
        if (sel_spd[0] > MAX_S) sel_spd[0] = MAX_S;
        if (sel_spd[1] > MAX_S) sel_spd[1] = MAX_S;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_dir <= 2'b11;
            tgt_spd <= '{default: '0};
            grant_q <= 1'b0;
        end else begin
            tgt_dir <= sel_dir;
            tgt_spd <= sel_spd;
            grant_q <= bus.a_valid;
        end
    end

    always_comb begin
        dir_d = dir_q;
        for (int w = 0; w < 2; w++) begin
            state_d[w] = state_q[w];
            spd_d[w]   = spd_q[w];
            dcnt_d[w]  = dcnt_q[w];
            diff[w]    = {1'b0, tgt_spd[w]} - {1'b0, spd_q[w]};
            if (bus.estop) begin
                state_d[w] = RUN;
                spd_d[w]   = '0;
            end else begin
                unique case (state_q[w])
                    RUN: begin
                        if (tgt_dir[w] != dir_q[w]) begin
                            dcnt_d[w]  = '0;
                            state_d[w] = (spd_q[w] != '0) ? DECEL : DEAD;
                        end else if (tick) begin
                            if (!diff[w][SPEED_W])
                                spd_d[w] = (diff[w] <= STEP_X) ? tgt_spd[w] : spd_q[w] + STEP_S;
                            else
                                spd_d[w] = ((-diff[w]) <= STEP_X) ? tgt_spd[w] : spd_q[w] - STEP_S;
                        end
                    end
                    DECEL: begin
                        if (tgt_dir[w] == dir_q[w]) begin
                            state_d[w] = RUN;
                        end else if (tick) begin
                            if ({1'b0, spd_q[w]} <= STEP_X) begin
                                spd_d[w]   = '0;
                                dcnt_d[w]  = '0;
                                state_d[w] = DEAD;
                            end else begin
                                spd_d[w] = spd_q[w] - STEP_S;
                            end
                        end
                    end
                    DEAD: begin
                        spd_d[w] = '0;
                        if (tgt_dir[w] == dir_q[w]) begin
                            state_d[w] = RUN;
                        end else if (tick) begin
                            if (dcnt_q[w] == DC_W'(DEAD_TICKS - 1)) begin
                                dir_d[w]   = tgt_dir[w];
                                state_d[w] = RUN;
                            end else begin
                                dcnt_d[w] = dcnt_q[w] + DC_W'(1);
                            end
                        end
                    end
                    default: state_d[w] = RUN;
                endcase
            end
        end
        settled_d = (state_q[0] == RUN) && (state_q[1] == RUN) &&
                    (spd_q[0] == tgt_spd[0]) && (spd_q[1] == tgt_spd[1]) &&
                    (dir_q == tgt_dir);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '{default: RUN};
            spd_q     <= '{default: '0};
            dcnt_q    <= '{default: '0};
            dir_q     <= 2'b11;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            spd_q     <= spd_d;
            dcnt_q    <= dcnt_d;
            dir_q     <= dir_d;
            settled_q <= settled_d;
        end
    end

    assign bus.speed_l = spd_q[0];
    assign bus.speed_r = spd_q[1];
    assign bus.dir_l   = dir_q[0];
    assign bus.dir_r   = dir_q[1];
    assign bus.grant_a = grant_q;
    assign bus.settled = settled_q;
endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// Directed bench for motor_cmd_ctrl with TICK_DIV=4, STEP=64, DEAD_TICKS=4; the bench keeps
// its own ramp-tick phase so every expected speed is counted in ticks from a known point.
module tb_motor_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;
    logic tk = 1'b0;
    logic prev_dir_l = 1'b1;

    motor_cmd_ctrl_if #(.SPEED_W(14)) bus ();

    motor_cmd_ctrl #(
        .SPEED_W(14), .MAX_SPEED(11000), .STEP(64), .TICK_DIV(4), .DEAD_TICKS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; ph mirrors where the ramp prescaler should be.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            ph = 0;
            tk = 1'b0;
        end else begin
            tk = (ph == 3);
            ph = (ph + 1) % 4;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        int c = 0;
        while (c < n) begin
            step();
            if (tk) c++;
        end
    endtask

    task automatic set_b(input logic d, input logic [13:0] s);
        bus.b_dir_l = d;  bus.b_dir_r = d;
        bus.b_speed_l = s; bus.b_speed_r = s;
    endtask

    task automatic set_a(input logic v, input logic d, input logic [13:0] s);
        bus.a_valid = v;
        bus.a_dir_l = d;  bus.a_dir_r = d;
        bus.a_speed_l = s; bus.a_speed_r = s;
    endtask

    // A direction edge on the left wheel must never carry a nonzero speed.
    always @(negedge clk) begin
        if (!rst && bus.dir_l !== prev_dir_l) begin
            checks++;
            assert (bus.speed_l === 14'd0)
            else begin
                errors++;
                $error("FAIL dir_edge_speed observed=%0d expected=0", bus.speed_l);
            end
        end
        prev_dir_l <= bus.dir_l;
    end

    initial begin
        set_a(1'b0, 1'b0, 14'd0);
        set_b(1'b0, 14'd0);
        bus.estop = 1'b0;
        step(); step();
        chk("rst_speed_l", bus.speed_l, 0);
        chk("rst_speed_r", bus.speed_r, 0);
        chk("rst_dir_l",   bus.dir_l, 1);
        chk("rst_dir_r",   bus.dir_r, 1);
        chk("rst_grant",   bus.grant_a, 0);
        chk("rst_settled", bus.settled, 0);

        // Ramp up to 1000
        set_b(1'b1, 14'd1000);
        rst = 1'b0;
        ticks(1);
        chk("ramp_t1", bus.speed_l, 64);
        ticks(14);
        chk("ramp_t15_l", bus.speed_l, 960);
        chk("ramp_t15_r", bus.speed_r, 960);
        ticks(1);
        chk("ramp_t16", bus.speed_l, 1000);
        chk("ramp_t16_settled", bus.settled, 0);
        step();
        chk("ramp_settled", bus.settled, 1);

        // Down to 640 (1000 -> 680 in 5 ticks, lands on 640 at the 6th)
        set_b(1'b1, 14'd640);
        ticks(5);
        chk("down_680", bus.speed_l, 680);
        ticks(1);
        chk("down_640", bus.speed_r, 640);

        // Abort a reversal after 3 decel ticks
        set_b(1'b0, 14'd640);
        ticks(3);
        chk("abort_448", bus.speed_l, 448);
        set_b(1'b1, 14'd640);
        ticks(1);
        chk("abort_512", bus.speed_l, 512);
        chk("abort_dir", bus.dir_l, 1);
        ticks(2);
        chk("abort_640", bus.speed_l, 640);
        step();
        chk("abort_settled", bus.settled, 1);

        // Full reversal from 640 forward (ph = 1 here)
        set_b(1'b0, 14'd640);
        ticks(9);
        chk("rev_64", bus.speed_l, 64);
        ticks(1);
        chk("rev_zero", bus.speed_l, 0);
        chk("rev_zero_dir", bus.dir_l, 1);
        ticks(3);
        chk("rev_dead3_dir", bus.dir_r, 1);
        chk("rev_dead3_spd", bus.speed_r, 0);
        ticks(1);
        chk("rev_flip_dir_l", bus.dir_l, 0);
        chk("rev_flip_dir_r", bus.dir_r, 0);
        chk("rev_flip_spd", bus.speed_l, 0);
        ticks(1);
        chk("rev_up_64", bus.speed_l, 64);
        ticks(9);
        chk("rev_up_640", bus.speed_l, 640);
        chk("rev_up_dir", bus.dir_l, 0);

        // Back to forward at 500: 10 decel + 4 dead + 8 ramp ticks
        set_b(1'b1, 14'd500);
        ticks(22);
        chk("b500_spd", bus.speed_l, 500);
        chk("b500_dir", bus.dir_l, 1);

        // A takes over with an over-range request
        set_a(1'b1, 1'b1, 14'd16000);
        step();
        chk("grant_on", bus.grant_a, 1);
        ticks(164);
        chk("clamp_10996", bus.speed_l, 10996);
        ticks(1);
        chk("clamp_11000", bus.speed_l, 11000);
        ticks(2);
        chk("clamp_hold", bus.speed_r, 11000);
        set_a(1'b0, 1'b1, 14'd16000);
        step();
        chk("grant_off", bus.grant_a, 0);
        ticks(164);
        chk("back_504", bus.speed_l, 504);
        ticks(1);
        chk("back_500", bus.speed_l, 500);

        // Estop: zero from 500, ramp to 320, then estop for 10 cycles
        set_b(1'b1, 14'd1000);
        bus.estop = 1'b1;
        step(); step();
        chk("estop0_spd", bus.speed_l, 0);
        bus.estop = 1'b0;
        ticks(5);
        chk("estop_pre_320", bus.speed_l, 320);
        bus.estop = 1'b1;
        step();
        chk("estop_spd_l", bus.speed_l, 0);
        chk("estop_spd_r", bus.speed_r, 0);
        chk("estop_dir", bus.dir_l, 1);
        repeat (9) step();
        chk("estop_hold", bus.speed_l, 0);
        bus.estop = 1'b0;
        ticks(1);
        chk("estop_rel_64", bus.speed_l, 64);
        ticks(1);
        chk("estop_rel_128", bus.speed_l, 128);

        // Reverse to 128 backward: 2 decel + 4 dead + 2 ramp
        set_b(1'b0, 14'd128);
        ticks(8);
        chk("bwd_128", bus.speed_l, 128);
        chk("bwd_dir", bus.dir_l, 0);

        // A asks forward; reset lands in the dead time
        set_a(1'b1, 1'b1, 14'd128);
        ticks(3);
        chk("dead_spd", bus.speed_l, 0);
        chk("dead_dir", bus.dir_l, 0);
        chk("dead_grant", bus.grant_a, 1);
        rst = 1'b1;
        step();
        chk("mrst_dir_l", bus.dir_l, 1);
        chk("mrst_dir_r", bus.dir_r, 1);
        chk("mrst_spd", bus.speed_l, 0);
        chk("mrst_grant", bus.grant_a, 0);
        chk("mrst_settled", bus.settled, 0);
        rst = 1'b0;
        ticks(1);
        chk("post_rst_64", bus.speed_l, 64);
        chk("post_rst_dir", bus.dir_l, 1);
        ticks(1);
        chk("post_rst_128", bus.speed_r, 128);
        step();
        chk("post_rst_settled", bus.settled, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
